seq_run_ctrl: RTL and testbench
===============================

Name: seq_run_ctrl

Overview:
Synthesizable run-control unit for the sequential RISC-V core (seq_wrapper). It sequences core reset, gates core progress through a clock enable, and stops execution on a cycle budget, an external halt or a core halt. It supports free-run, bounded-run and single-step modes, and sits between the top level / debug logic and the core's reset and enable inputs.

Parameters:
CNT_W, 32, width of run_len and cycle_cnt
RST_HOLD, 4, cycles core_rst is held in the RESET state (min 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  launch request; sampled only in IDLE or DONE
mode  in  2  0 free-run, 1 bounded, 2 single-step, 3 reserved (treated as 0); latched on accepted start
run_len  in  CNT_W  enabled-cycle budget for bounded mode; latched on accepted start
step  in  1  single-step request, level-sampled per cycle
halt_req  in  1  external stop request
core_halt  in  1  halt indication from the core (ecall/ebreak retire)
core_rst  out  1  reset to the core, active-high
core_en  out  1  clock enable to the core; one enabled cycle = one core step
busy  out  1  high in RESET, RUN, STEP
done  out  1  high in DONE
done_cause  out  2  0 none, 1 halt_req, 2 core_halt, 3 budget exhausted
cycle_cnt  out  CNT_W  enabled cycles since last accepted start

Behaviour:
- rst asserted (any time, including mid-run): state=IDLE, core_rst=1, core_en=0, busy=0, done=0, done_cause=0, cycle_cnt=0, hold counter=0, latched mode/run_len=0.
- States: IDLE, RESET, RUN, STEP, DONE. All outputs except core_en are registered or decoded from state only.
- IDLE: core_rst=1, core_en=0. start=1 -> latch mode/run_len, clear cycle_cnt and done_cause, load hold counter, go to RESET.
- RESET: core_rst=1, core_en=0, for exactly RST_HOLD cycles. Then:
  - mode 2 -> STEP.
  - mode 1 with run_len=0 -> DONE, cause 3, zero enabled cycles.
  - otherwise -> RUN.
  - halt_req during RESET -> DONE, cause 1; core_rst deasserts on entry to DONE.
- RUN: core_rst=0, core_en=1 every cycle; cycle_cnt increments each cycle.
  - Terminating conditions are evaluated in the enabled cycle. That cycle counts, and the next state is DONE.
  - Conditions, in priority order: halt_req (cause 1) > core_halt (cause 2) > bounded mode with cycle_cnt==run_len-1 (cause 3).
  - Bounded mode therefore yields exactly run_len enabled cycles.
  - Free-run stops only on halt_req or core_halt.
- STEP: core_rst=0; core_en=step, combinational, same cycle.
  - Each cycle with step=1 is one enabled cycle and increments cycle_cnt.
  - halt_req -> DONE, cause 1. If step is also high that cycle, core_en is still 1 and counted.
  - core_halt in an enabled cycle -> DONE, cause 2.
  - run_len ignored.
- DONE: core_en=0, core_rst=0 (core state preserved for inspection), done=1. cycle_cnt and done_cause hold. start -> RESET, full relaunch.
- start while busy is ignored; mode/run_len changes while busy have no effect.
- cycle_cnt saturates at 2^CNT_W-1 (no wrap); free-run continues.
- core_halt/halt_req in IDLE or DONE are ignored.
- No latency beyond that stated: start at edge N -> core_rst held in cycles N+1..N+RST_HOLD -> first core_en at cycle N+RST_HOLD+1.

Test Plan:
- Bounded: RST_HOLD=4, mode=1, run_len=10, start pulse -> core_rst high 4 cycles after start, then core_en high exactly 10 consecutive cycles; done=1, done_cause=3, cycle_cnt=10, core_en=0 thereafter.
- Zero budget: mode=1, run_len=0 -> RESET 4 cycles then DONE directly; core_en never asserted; cause 3, cycle_cnt=0.
- Free-run with core halt: mode=0; core_halt pulsed on 7th enabled cycle -> cycle_cnt=7, cause 2; simultaneous halt_req+core_halt on a further run -> cause 1.
- Single-step: mode=2, step pulsed on 3 separate cycles with gaps -> core_en mirrors step exactly (3 cycles), cycle_cnt=3, busy=1; halt_req -> DONE cause 1.
- Async reset mid-RUN: assert rst between clock edges at cycle 5 of a run_len=20 run -> core_en=0, core_rst=1, busy=0, cycle_cnt=0 immediately, before the next edge; start after release relaunches normally.
- Saturation/ignore: CNT_W=4, mode=0, no halts for 20 cycles -> cycle_cnt sticks at 15; start pulses during RUN are ignored (no return to RESET).

Source files
------------

// File: rtl/seq_run_ctrl_if.sv
// Run-control bus: launch/step/halt requests in, core reset/enable and
// run status out. The controller sits on the slave side.
interface seq_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] run_len;
  logic             step;
  logic             halt_req;
  logic             core_halt;
  logic             core_rst;
  logic             core_en;
  logic             busy;
  logic             done;
  logic [1:0]       done_cause;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output start, mode, run_len, step, halt_req, core_halt,
    input  core_rst, core_en, busy, done, done_cause, cycle_cnt
  );

  modport slave (
    input  start, mode, run_len, step, halt_req, core_halt,
    output core_rst, core_en, busy, done, done_cause, cycle_cnt
  );
endinterface

// File: rtl/seq_run_ctrl.sv
// Run-control unit for the sequential core: sequences core reset, gates
// core progress with a clock enable, and stops on a cycle budget, an
// external halt or a core halt. Supports free-run, bounded and single-step.
module seq_run_ctrl #(
  parameter int CNT_W    = 32,
  parameter int RST_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_run_ctrl_if.slave bus
);

  localparam int              HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_BOUND = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_HALT   = 2'd1;
  localparam logic [1:0] CAUSE_CORE   = 2'd2;
  localparam logic [1:0] CAUSE_BUDGET = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              core_en;

  // Enabled-cycle counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));

  // State and run-context registers; rst returns everything to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      mode_q    <= MODE_FREE;
      run_len_q <= '0;
      cnt_q     <= '0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      mode_q    <= mode_d;
      run_len_q <= run_len_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state logic and the combinational core enable.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    mode_d    = mode_q;
    run_len_d = run_len_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    core_en   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_RESET;
          hold_d    = HOLD_LOAD;
          mode_d    = (bus.mode == MODE_RSVD) ? MODE_FREE : bus.mode;
          run_len_d = bus.run_len;
          cnt_d     = '0;
          cause_d   = CAUSE_NONE;
        end else begin
          state_d = state_q;
        end
      end

      S_RESET: begin
        if (bus.halt_req) begin
          state_d = S_DONE;
          cause_d = CAUSE_HALT;
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (mode_q == MODE_STEP) begin
          state_d = S_STEP;
        end else if ((mode_q == MODE_BOUND) && (run_len_q == '0)) begin
          state_d = S_DONE;
          cause_d = CAUSE_BUDGET;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // The terminating cycle is itself an enabled, counted cycle.
        core_en = 1'b1;
        cnt_d   = cnt_inc;
        if (bus.halt_req) begin
          state_d = S_DONE;
          cause_d = CAUSE_HALT;
        end else if (bus.core_halt) begin
          state_d = S_DONE;
          cause_d = CAUSE_CORE;
        end else if ((mode_q == MODE_BOUND) && (cnt_q == (run_len_q - CNT_W'(1)))) begin
          state_d = S_DONE;
          cause_d = CAUSE_BUDGET;
        end else begin
          state_d = S_RUN;
        end
      end

      S_STEP: begin
        core_en = bus.step;
        if (bus.step) begin
          cnt_d = cnt_inc;
        end else begin
          cnt_d = cnt_q;
        end
        if (bus.halt_req) begin
          state_d = S_DONE;
          cause_d = CAUSE_HALT;
        end else if (bus.step && bus.core_halt) begin
          state_d = S_DONE;
          cause_d = CAUSE_CORE;
        end else begin
          state_d = S_STEP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from state or taken straight from registers.
  assign bus.core_rst   = (state_q == S_IDLE) || (state_q == S_RESET);
  assign bus.core_en    = core_en;
  assign bus.busy       = (state_q == S_RESET) || (state_q == S_RUN) || (state_q == S_STEP);
  assign bus.done       = (state_q == S_DONE);
  assign bus.done_cause = cause_q;
  assign bus.cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Self-checking bench for seq_run_ctrl: directed and randomized runs,
// expected results computed from the run-control rules with plain arithmetic.
module tb_seq_run_ctrl;

  localparam int RST_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_run_ctrl_if #(.CNT_W(32)) u ();
  seq_run_ctrl_if #(.CNT_W(4))  u4 ();

  seq_run_ctrl #(.CNT_W(32), .RST_HOLD(RST_HOLD)) dut (.clk(clk), .rst(rst), .bus(u));
  seq_run_ctrl #(.CNT_W(4),  .RST_HOLD(RST_HOLD)) dut4 (.clk(clk), .rst(rst), .bus(u4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One launch; h/c = enabled-cycle index carrying halt_req/core_halt,
  // r = reset-cycle index carrying halt_req (0 = never).
  task automatic run_case(input logic [1:0] m, input logic [31:0] len,
                          input int h, input int c, input int r);
    int         exp_en, exp_rc, rc, en, cyc, first_en, bad;
    logic [1:0] exp_cause;
    bit         got_done;
    exp_rc = RST_HOLD;
    exp_en = 1 << 30;
    exp_cause = 2'd0;
    if (r != 0 && r <= RST_HOLD) begin
      exp_rc = r; exp_en = 0; exp_cause = 2'd1;
    end else begin
      if (h != 0) begin exp_en = h; exp_cause = 2'd1; end
      if (c != 0 && c < exp_en) begin exp_en = c; exp_cause = 2'd2; end
      if (m == 2'd1 && int'(len) < exp_en) begin exp_en = int'(len); exp_cause = 2'd3; end
    end

    @(negedge clk);
    u.start = 1'b1; u.mode = m; u.run_len = len;
    rc = 0; en = 0; cyc = 0; first_en = -1; bad = 0; got_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      u.start = 1'b0; u.halt_req = 1'b0; u.core_halt = 1'b0;
      if (u.done) begin got_done = 1'b1; break; end
      cyc++;
      if ((u.core_rst && u.core_en) || (u.busy && !u.core_rst && !u.core_en)) bad++;
      if (u.core_rst) begin
        rc++;
        if (rc == r) u.halt_req = 1'b1;
      end else if (u.core_en) begin
        if (first_en < 0) first_en = cyc;
        en++;
        if (en == h) u.halt_req = 1'b1;
        if (en == c) u.core_halt = 1'b1;
        u.start   = 1'($urandom_range(0, 1));
        u.mode    = 2'($urandom_range(0, 3));
        u.run_len = $urandom;
      end
    end
    u.start = 1'b0;
    chk("done_reached", got_done, 1'b1);
    chk("reset_cycles", rc, exp_rc);
    chk("enabled_cycles", en, exp_en);
    chk("cycle_cnt", u.cycle_cnt, exp_en);
    chk("done_cause", u.done_cause, exp_cause);
    chk("done_outputs", {u.done, u.busy, u.core_en, u.core_rst}, 4'b1000);
    chk("no_gap", bad, 0);
    if (exp_en > 0) chk("first_en_cycle", first_en, RST_HOLD + 1);

    // Halt inputs in DONE must not disturb the result.
    u.halt_req = 1'b1; u.core_halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    u.halt_req = 1'b0; u.core_halt = 1'b0;
    chk("done_hold", u.done, 1'b1);
    chk("cause_hold", u.done_cause, exp_cause);
    chk("cnt_hold", u.cycle_cnt, exp_en);
  endtask

  // Single-step launch; pat bit i = step level in step cycle i.
  task automatic step_case(input logic [15:0] pat, input int n, input bit end_core);
    int   nexp;
    logic s;
    @(negedge clk);
    u.start = 1'b1; u.mode = 2'd2; u.run_len = $urandom;
    @(negedge clk);
    u.start = 1'b0;
    for (int i = 0; i < RST_HOLD; i++) @(negedge clk);
    chk("step_entry", {u.busy, u.core_rst, u.done}, 3'b100);
    nexp = 0;
    for (int i = 0; i < n; i++) begin
      s = pat[i];
      u.step = s;
      u.core_halt = !s && 1'($urandom_range(0, 1));
      #1;
      chk("step_mirror", u.core_en, s);
      if (s) nexp++;
      @(negedge clk);
      chk("step_busy", u.busy, 1'b1);
    end
    s = end_core ? 1'b1 : 1'($urandom_range(0, 1));
    u.step = s; u.halt_req = !end_core; u.core_halt = end_core;
    #1;
    chk("step_last_mirror", u.core_en, s);
    if (s) nexp++;
    @(negedge clk);
    u.step = 1'b0; u.halt_req = 1'b0; u.core_halt = 1'b0;
    chk("step_done", {u.done, u.busy, u.core_en, u.core_rst}, 4'b1000);
    chk("step_cause", u.done_cause, end_core ? 2'd2 : 2'd1);
    chk("step_cnt", u.cycle_cnt, nexp);
  endtask

  initial begin
    logic [1:0]  m;
    logic [31:0] len;
    int          h, c, r, en;

    u.start = 1'b0; u.mode = 2'd0; u.run_len = '0; u.step = 1'b0;
    u.halt_req = 1'b0; u.core_halt = 1'b0;
    u4.start = 1'b0; u4.mode = 2'd0; u4.run_len = '0; u4.step = 1'b0;
    u4.halt_req = 1'b0; u4.core_halt = 1'b0;

    #12;
    chk("reset_state", {u.core_rst, u.core_en, u.busy, u.done}, 4'b1000);
    chk("reset_cause", u.done_cause, 2'd0);
    chk("reset_cnt", u.cycle_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", {u.core_rst, u.core_en, u.busy, u.done}, 4'b1000);

    // Directed runs.
    run_case(2'd1, 32'd10, 0, 0, 0);   // bounded, 10 cycles
    run_case(2'd1, 32'd0,  0, 0, 0);   // zero budget
    run_case(2'd0, 32'd0,  0, 7, 0);   // free-run, core halt on 7th
    run_case(2'd0, 32'd0,  5, 5, 0);   // simultaneous halts: halt_req wins
    run_case(2'd3, 32'd2,  4, 0, 0);   // reserved mode behaves as free-run
    run_case(2'd1, 32'd20, 0, 0, 2);   // halt_req during RESET
    run_case(2'd1, 32'd6,  0, 6, 0);   // core halt ties budget end

    // Single-step.
    step_case(16'b0000_0000_1010_0010, 8, 1'b0);
    step_case(16'($urandom), 12, 1'b1);

    // Randomized runs.
    for (int k = 0; k < 10; k++) begin
      m = 2'($urandom_range(0, 3));
      if (m == 2'd2) m = 2'd1;
      len = $urandom_range(0, 25);
      h = int'($urandom_range(0, 30));
      c = int'($urandom_range(0, 30));
      r = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, RST_HOLD)) : 0;
      if (m != 2'd1 && h == 0 && c == 0) h = int'($urandom_range(1, 30));
      run_case(m, len, h, c, r);
    end

    // Asynchronous reset in the 5th enabled cycle of a 20-cycle run.
    @(negedge clk);
    u.start = 1'b1; u.mode = 2'd1; u.run_len = 32'd20;
    @(negedge clk);
    u.start = 1'b0;
    en = 0;
    for (int i = 0; i < 50; i++) begin
      if (u.core_en) en++;
      if (en == 5) break;
      @(negedge clk);
    end
    chk("pre_reset_en", en, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {u.core_en, u.core_rst, u.busy, u.done}, 4'b0100);
    chk("async_rst_cnt", u.cycle_cnt, 0);
    chk("async_rst_cause", u.done_cause, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    run_case(2'd1, 32'd20, 0, 0, 0);

    // Saturation on the 4-bit instance, with start ignored while running.
    @(negedge clk);
    u4.start = 1'b1; u4.mode = 2'd0;
    @(negedge clk);
    u4.start = 1'b0;
    en = 0;
    for (int i = 0; i < RST_HOLD + 25; i++) begin
      if (u4.core_en) begin
        en++;
        chk("sat_cnt", u4.cycle_cnt, (en - 1 > 15) ? 15 : en - 1);
      end
      if (en > 0) chk("sat_no_restart", {u4.core_rst, u4.busy}, 2'b01);
      u4.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    u4.start = 1'b0;
    chk("sat_enabled", en, 25 - 1 + 1);
    u4.halt_req = 1'b1;
    @(negedge clk);
    u4.halt_req = 1'b0;
    chk("sat_done", {u4.done, u4.core_en}, 2'b10);
    chk("sat_final_cnt", u4.cycle_cnt, 4'd15);
    chk("sat_cause", u4.done_cause, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
